sipo_rx_ctrl: RTL and testbench

Sequencing controller for the 8-bit serial-in/parallel-out shift register on the Lab4 inter-board serial link.
- Synchronises the raw serial line and detects a start bit using an oversampling tick.
- Emits one shift-enable pulse at the centre of each data bit, then checks the stop bit.
- Captures the SIPO parallel word into a holding register and presents it to the consumer with a valid/ack handshake.
- Sits between the pin-level serial input and the SIPO/consumer logic.

---
 rtl/sipo_rx_pkg.sv | 14 +
 rtl/sync2.sv | 23 ++
 rtl/sipo_rx_ctrl.sv | 128 ++++++++++++
 tb/tb_sipo_rx_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_rx_pkg.sv
// Shared types and defaults for the serial-link SIPO receive controller.
package sipo_rx_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous input; both stages reset to 1 (idle line).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta->q a true two-stage pipeline;
  // blocking here would collapse both stages into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sipo_rx_ctrl.sv
// Receive sequencer for the 8-bit SIPO: start detect, mid-bit shift pulses,
// stop check, holding register with valid/ack handshake and overrun flag.
module sipo_rx_ctrl
  import sipo_rx_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 serial_in,
  output logic                 rx_bit,
  output logic                 sipo_shift_en,
  input  logic [DATA_BITS-1:0] sipo_q,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_e     state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          shift, capture, ferr;

  sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (rx_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so that paths
    // that do not assign it hold a defined value instead of inferring a latch.
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift   = 1'b0;
    capture = 1'b0;
    ferr    = 1'b0;

    if (baud_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_bit) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_bit ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == TICK_END) begin
            shift  = 1'b1;
            tick_d = '0;
            bit_d  = bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            state_d = IDLE;
            if (rx_bit) capture = 1'b1;
            else        ferr    = 1'b1;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pulses and busy are forced low while rst is held, not only after the edge.
  assign sipo_shift_en = shift & ~rst;
  assign frame_err     = ferr & ~rst;
  assign busy          = (state_q != IDLE) & ~rst;

  // A capture coinciding with rx_ack consumes the old word, so no overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (capture) begin
      rx_byte  <= sipo_q;
      rx_valid <= 1'b1;
      overrun  <= rx_valid & ~rx_ack;
    end else if (rx_ack && rx_valid) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sipo_rx_ctrl.sv
// Directed bench for sipo_rx_ctrl with an external 8-bit SIPO model attached.
module tb_sipo_rx_ctrl;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       serial_in = 1'b1;
  logic       rx_bit;
  logic       sipo_shift_en;
  logic [7:0] sipo_q = 8'h00;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ack = 1'b0;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;

  int tick_div = 1;
  int div_cnt  = 0;

  int cyc = 0;
  int pulses, stray, ferr_cnt, last_pulse, min_gap, max_gap;

  sipo_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .serial_in     (serial_in),
    .rx_bit        (rx_bit),
    .sipo_shift_en (sipo_shift_en),
    .sipo_q        (sipo_q),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .rx_ack        (rx_ack),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // External SIPO: shifts toward bit 7.
  always @(posedge clk) if (sipo_shift_en) sipo_q <= {sipo_q[6:0], rx_bit};

  always @(posedge clk) begin
    #1;
    if (div_cnt >= tick_div - 1) begin
      div_cnt   = 0;
      baud_tick = 1'b1;
    end else begin
      div_cnt   = div_cnt + 1;
      baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sipo_shift_en) begin
      if (!baud_tick) stray = stray + 1;
      if (pulses > 0) begin
        if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
        if (cyc - last_pulse > max_gap) max_gap = cyc - last_pulse;
      end
      pulses     = pulses + 1;
      last_pulse = cyc;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    pulses   = 0;
    stray    = 0;
    ferr_cnt = 0;
    min_gap  = 1_000_000;
    max_gap  = 0;
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    wait_clk(OS * tick_div);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
    serial_in = 1'b1;
  endtask

  task automatic ack();
    rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
  endtask

  initial begin
    clr_mon();
    last_pulse = 0;

    wait_clk(3);
    check("rst_rx_bit", rx_bit, 1);
    check("rst_shift_en", sipo_shift_en, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_rx_byte", rx_byte, 8'h00);
    rst = 1'b0;
    wait_clk(10);

    // 1: frame 0xA5, tick every clk
    clr_mon();
    send_frame(8'hA5, 1'b1);
    wait_clk(20);
    check("t1_pulses", pulses, 8);
    check("t1_min_gap", min_gap, 16);
    check("t1_max_gap", max_gap, 16);
    check("t1_valid", rx_valid, 1);
    check("t1_byte", rx_byte, 8'hA5);
    check("t1_ferr", ferr_cnt, 0);
    check("t1_stray", stray, 0);
    ack();
    check("t1_ack_clears", rx_valid, 0);

    // 2: 4-tick low glitch
    clr_mon();
    serial_in = 1'b0;
    wait_clk(4);
    serial_in = 1'b1;
    wait_clk(40);
    check("t2_pulses", pulses, 0);
    check("t2_valid", rx_valid, 0);
    check("t2_busy", busy, 0);

    // 3: 0x3C with bad stop bit
    clr_mon();
    send_frame(8'h3C, 1'b0);
    wait_clk(40);
    check("t3_ferr_pulses", ferr_cnt, 1);
    check("t3_valid", rx_valid, 0);
    check("t3_byte_kept", rx_byte, 8'hA5);

    // 4: back-to-back 0x11, 0x22 without ack
    clr_mon();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clk(20);
    check("t4_pulses", pulses, 16);
    check("t4_byte", rx_byte, 8'h22);
    check("t4_valid", rx_valid, 1);
    check("t4_overrun", overrun, 1);
    check("t4_ferr", ferr_cnt, 0);
    ack();
    check("t4_ack_valid", rx_valid, 0);
    check("t4_ack_overrun", overrun, 0);

    // 5: reset after third shift pulse, then 0x81
    clr_mon();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t5_pulses_pre", pulses, 3);
    serial_in = 1'b1;
    rst = 1'b1;
    wait_clk(1);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_shift_en", sipo_shift_en, 0);
    check("t5_rst_valid", rx_valid, 0);
    check("t5_rst_byte", rx_byte, 8'h00);
    check("t5_rst_overrun", overrun, 0);
    check("t5_rst_rx_bit", rx_bit, 1);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(20);
    clr_mon();
    send_frame(8'h81, 1'b1);
    wait_clk(20);
    check("t5_pulses", pulses, 8);
    check("t5_byte", rx_byte, 8'h81);
    check("t5_valid", rx_valid, 1);
    ack();

    // 6: tick every 5 clk, frame 0xFF
    tick_div = 5;
    wait_clk(20);
    clr_mon();
    send_frame(8'hFF, 1'b1);
    wait_clk(100);
    check("t6_pulses", pulses, 8);
    check("t6_min_gap", min_gap, 80);
    check("t6_max_gap", max_gap, 80);
    check("t6_stray", stray, 0);
    check("t6_byte", rx_byte, 8'hFF);
    check("t6_valid", rx_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
